// File: rtl/eth_mac_pkg.sv
// Shared constants and types for the Ethernet MAC flow-control path.
// Holds MAC-control PAUSE frame fields and the pause controller state set.
package eth_mac_pkg;

    localparam logic [47:0] PAUSE_DA           = 48'h0180C2000001;
    localparam logic [15:0] ETHERTYPE_MAC_CTRL = 16'h8808;
    localparam logic [15:0] OPCODE_PAUSE       = 16'h0001;
    localparam int          PAUSE_FRAME_LEN    = 60;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_USER,
        ST_PAUSE_TX
    } pause_ctrl_state_t;

    // Byte 'idx' of a PAUSE frame; everything past the quanta is padding.
    function automatic logic [7:0] pause_byte(
        input logic [5:0]  idx,
        input logic [47:0] mac,
        input logic [15:0] quanta
    );
        logic [47:0] da;
        logic [15:0] etype;
        logic [15:0] opcode;
        logic [7:0]  b;
        int          i;
        da     = PAUSE_DA;
        etype  = ETHERTYPE_MAC_CTRL;
        opcode = OPCODE_PAUSE;
        i      = int'(idx);
        b      = 8'h00;
        unique case (1'b1)
            (idx <= 6'd5):                 b = da[8*(5-i) +: 8];
            (idx >= 6'd6 && idx <= 6'd11): b = mac[8*(11-i) +: 8];
            (idx == 6'd12):                b = etype[15:8];
            (idx == 6'd13):                b = etype[7:0];
            (idx == 6'd14):                b = opcode[15:8];
            (idx == 6'd15):                b = opcode[7:0];
            (idx == 6'd16):                b = quanta[15:8];
            (idx == 6'd17):                b = quanta[7:0];
            default:                       b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eth_pause_timer.sv
// Received-PAUSE hold-off counter: quanta count plus per-quantum cycle timer.
// Timer terminal count follows GMII or MII pacing via mii_select.
module eth_pause_timer #(
    parameter int QUANTA_WIDTH        = 16,
    parameter int GMII_CYC_PER_QUANTA = 64,
    parameter int MII_CYC_PER_QUANTA  = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [QUANTA_WIDTH-1:0] load_quanta,
    input  logic                    clk_enable,
    input  logic                    mii_select,
    output logic                    paused
);

    localparam int MAX_TC = (GMII_CYC_PER_QUANTA > MII_CYC_PER_QUANTA ?
                             GMII_CYC_PER_QUANTA : MII_CYC_PER_QUANTA) - 1;
    localparam int TW = (MAX_TC > 0) ? $clog2(MAX_TC + 1) : 1;

    localparam logic [TW-1:0] GMII_TC = TW'(GMII_CYC_PER_QUANTA - 1);
    localparam logic [TW-1:0] MII_TC  = TW'(MII_CYC_PER_QUANTA - 1);

    logic [QUANTA_WIDTH-1:0] pause_count;
    logic [TW-1:0]           timer;
    logic [TW-1:0]           term;
    logic                    at_term;

    assign term    = mii_select ? MII_TC : GMII_TC;
    assign at_term = (timer >= term);
    assign paused  = (pause_count != '0);

    // Load on a received PAUSE, otherwise count enabled cycles down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            pause_count <= '0;
            timer       <= '0;
        end else if (load) begin
            pause_count <= load_quanta;
            timer       <= '0;
        end else if (pause_count != '0 && clk_enable) begin
            if (at_term) begin
                timer       <= '0;
                pause_count <= pause_count - 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_mac_pause_ctrl.sv
// 802.3x flow control ahead of the GMII TX framer: RX-pause hold-off and PAUSE injection.
// Build option ETH_PAUSE_STATS_EN adds saturating PAUSE tx/rx frame counters.
module eth_mac_pause_ctrl
    import eth_mac_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int QUANTA_WIDTH        = 16,
    parameter int GMII_CYC_PER_QUANTA = 64,
    parameter int MII_CYC_PER_QUANTA  = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    input  logic                    tx_pause_req,
    input  logic [QUANTA_WIDTH-1:0] tx_pause_quanta,
    input  logic [47:0]             src_mac,
    input  logic                    rx_pause_valid,
    input  logic [QUANTA_WIDTH-1:0] rx_pause_quanta,
    input  logic                    clk_enable,
    input  logic                    mii_select,
    output logic                    paused,
    output logic                    busy
`ifdef ETH_PAUSE_STATS_EN
    ,
    output logic [31:0]             stat_pause_tx,
    output logic [31:0]             stat_pause_rx
`endif
);

    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("eth_mac_pause_ctrl: only DATA_WIDTH=8 is supported");
    end

    localparam logic [5:0] LAST_IDX = 6'(PAUSE_FRAME_LEN - 1);

    pause_ctrl_state_t       state_q, state_d;
    logic [5:0]              idx_q, idx_d;
    logic                    pend_q;
    logic [QUANTA_WIDTH-1:0] pend_quanta_q;
    logic [QUANTA_WIDTH-1:0] frame_quanta_q;
    logic                    enter_pause;

    eth_pause_timer #(
        .QUANTA_WIDTH        (QUANTA_WIDTH),
        .GMII_CYC_PER_QUANTA (GMII_CYC_PER_QUANTA),
        .MII_CYC_PER_QUANTA  (MII_CYC_PER_QUANTA)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (rx_pause_valid),
        .load_quanta (rx_pause_quanta),
        .clk_enable  (clk_enable),
        .mii_select  (mii_select),
        .paused      (paused)
    );

    assign busy = (state_q != ST_IDLE);

    // Arbitration and stream muxing; user beats pass through with zero latency.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        enter_pause   = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d     = ST_PAUSE_TX;
                    idx_d       = 6'd0;
                    enter_pause = 1'b1;
                end else if (!paused && s_axis_tvalid) begin
                    m_axis_tdata  = s_axis_tdata;
                    m_axis_tvalid = 1'b1;
                    m_axis_tlast  = s_axis_tlast;
                    m_axis_tuser  = s_axis_tuser;
                    s_axis_tready = m_axis_tready;
                    if (m_axis_tready && !s_axis_tlast) begin
                        state_d = ST_USER;
                    end
                end
            end
            ST_USER: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE_TX: begin
                m_axis_tdata  = DATA_WIDTH'(pause_byte(idx_q, src_mac,
                                                       16'(frame_quanta_q)));
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (idx_q == LAST_IDX);
                if (m_axis_tready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            m_axis_tdata  = '0;
            m_axis_tvalid = 1'b0;
            m_axis_tlast  = 1'b0;
            m_axis_tuser  = 1'b0;
            s_axis_tready = 1'b0;
        end
    end

    // State, byte index and the last-wins pending PAUSE request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= 6'd0;
            pend_q         <= 1'b0;
            pend_quanta_q  <= '0;
            frame_quanta_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (tx_pause_req) begin
                pend_q        <= 1'b1;
                pend_quanta_q <= tx_pause_quanta;
            end else if (enter_pause) begin
                pend_q <= 1'b0;
            end
            if (enter_pause) begin
                frame_quanta_q <= pend_quanta_q;
            end
        end
    end

`ifdef ETH_PAUSE_STATS_EN
    logic pause_done;

    assign pause_done = (state_q == ST_PAUSE_TX) && m_axis_tready &&
                        (idx_q == LAST_IDX);

    // Saturating counts of PAUSE frames sent and received.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pause_tx <= '0;
            stat_pause_rx <= '0;
        end else begin
            if (pause_done && stat_pause_tx != '1) begin
                stat_pause_tx <= stat_pause_tx + 32'd1;
            end
            if (rx_pause_valid && stat_pause_rx != '1) begin
                stat_pause_rx <= stat_pause_rx + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_mac_pause_ctrl.sv
// Directed bench for eth_mac_pause_ctrl: vector table plus multi-cycle sequences.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_eth_mac_pause_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        tx_pause_req;
    logic [15:0] tx_pause_quanta;
    logic [47:0] src_mac;
    logic        rx_pause_valid;
    logic [15:0] rx_pause_quanta;
    logic        clk_enable;
    logic        mii_select;
    logic        paused;
    logic        busy;
`ifdef ETH_PAUSE_STATS_EN
    logic [31:0] stat_pause_tx;
    logic [31:0] stat_pause_rx;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    eth_mac_pause_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .tx_pause_req    (tx_pause_req),
        .tx_pause_quanta (tx_pause_quanta),
        .src_mac         (src_mac),
        .rx_pause_valid  (rx_pause_valid),
        .rx_pause_quanta (rx_pause_quanta),
        .clk_enable      (clk_enable),
        .mii_select      (mii_select),
        .paused          (paused),
        .busy            (busy)
`ifdef ETH_PAUSE_STATS_EN
        ,
        .stat_pause_tx   (stat_pause_tx),
        .stat_pause_rx   (stat_pause_rx)
`endif
    );

    typedef struct {
        logic        rst;
        logic [7:0]  sd;
        logic        sv;
        logic        sl;
        logic        su;
        logic        mr;
        logic        treq;
        logic        rxv;
        logic [15:0] rxq;
        logic [7:0]  md;
        logic        mv;
        logic        ml;
        logic        mu;
        logic        sr;
        logic        ps;
        logic        bz;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic r, input logic [7:0] sd, input logic sv,
        input logic sl, input logic su, input logic mr,
        input logic tq, input logic rv, input logic [15:0] rq,
        input logic [7:0] md, input logic mv, input logic ml,
        input logic mu, input logic sr, input logic ps, input logic bz
    );
        vec_t v;
        v.rst = r;  v.sd = sd; v.sv = sv; v.sl = sl; v.su = su;
        v.mr = mr;  v.treq = tq; v.rxv = rv; v.rxq = rq;
        v.md = md;  v.mv = mv; v.ml = ml; v.mu = mu;
        v.sr = sr;  v.ps = ps; v.bz = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst             = 1'b1;
        s_axis_tdata    = 8'h00;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        s_axis_tuser    = 1'b0;
        m_axis_tready   = 1'b1;
        tx_pause_req    = 1'b0;
        tx_pause_quanta = 16'h0000;
        rx_pause_valid  = 1'b0;
        rx_pause_quanta = 16'h0000;
        clk_enable      = 1'b1;
        mii_select      = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Receive PAUSE beats [first, last_n) and check them against the frame layout.
    task automatic collect(input logic [15:0] q, input bit rnd,
                           input int first, input int last_n);
        logic [7:0] exp [60];
        int         k;
        int         cyc;
        for (int i = 0; i < 60; i++) exp[i] = 8'h00;
        exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'hC2;
        exp[3] = 8'h00; exp[4] = 8'h00; exp[5] = 8'h01;
        for (int i = 0; i < 6; i++) exp[6+i] = src_mac[47-8*i -: 8];
        exp[12] = 8'h88; exp[13] = 8'h08;
        exp[14] = 8'h00; exp[15] = 8'h01;
        exp[16] = q[15:8]; exp[17] = q[7:0];
        k   = first;
        cyc = 0;
        while (k < last_n && cyc < 2000) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                chk($sformatf("pause_byte%0d", k),
                    {21'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                     s_axis_tready},
                    {21'd0, exp[k], 1'(k == 59), 1'b0, 1'b0});
                k++;
            end
            tick;
            cyc++;
        end
        if (k < last_n) chk("pause_frame_timeout", k, last_n);
        m_axis_tready = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] e;
        int          cnt;
        int          bad;
        bit          rel;

        src_mac = 48'h020000000001;
        do_reset;

        //       rst sd    sv sl su mr tq rv rq      md    mv ml mu sr ps bz
        vt.push_back(mk(1, 8'hAA, 1, 0, 0, 1, 0, 0, 16'd0, 8'h00, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 8'h11, 1, 0, 0, 1, 0, 0, 16'd0, 8'h11, 1, 0, 0, 1, 0, 0));
        vt.push_back(mk(0, 8'h22, 1, 0, 0, 0, 0, 0, 16'd0, 8'h22, 1, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 8'h22, 1, 1, 1, 1, 0, 0, 16'd0, 8'h22, 1, 1, 1, 1, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 16'd0, 8'h00, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 8'h33, 1, 1, 0, 1, 0, 0, 16'd0, 8'h33, 1, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 8'h44, 1, 1, 0, 1, 0, 1, 16'd5, 8'h44, 1, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 8'h55, 1, 1, 0, 1, 0, 0, 16'd0, 8'h00, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 8'h55, 1, 1, 0, 1, 0, 1, 16'd0, 8'h00, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 8'h66, 1, 1, 0, 1, 0, 0, 16'd0, 8'h66, 1, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 0, 16'd0, 8'h00, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 8'h77, 1, 1, 0, 1, 0, 0, 16'd0, 8'h00, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 8'h77, 1, 1, 0, 1, 0, 0, 16'd0, 8'h01, 1, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 8'h77, 1, 1, 0, 0, 0, 0, 16'd0, 8'h80, 1, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 8'h77, 1, 1, 0, 1, 0, 0, 16'd0, 8'h80, 1, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 8'h77, 1, 1, 0, 1, 0, 0, 16'd0, 8'hC2, 1, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 16'd0, 8'h00, 1, 0, 0, 0, 0, 1));

        tx_pause_quanta = 16'h1234;
        for (int i = 0; i < vt.size(); i++) begin
            rst             = vt[i].rst;
            s_axis_tdata    = vt[i].sd;
            s_axis_tvalid   = vt[i].sv;
            s_axis_tlast    = vt[i].sl;
            s_axis_tuser    = vt[i].su;
            m_axis_tready   = vt[i].mr;
            tx_pause_req    = vt[i].treq;
            rx_pause_valid  = vt[i].rxv;
            rx_pause_quanta = vt[i].rxq;
            @(negedge clk);
            e = {18'd0, vt[i].mv ? vt[i].md : 8'h00,
                 vt[i].mv ? vt[i].ml : 1'b0, vt[i].mv ? vt[i].mu : 1'b0,
                 vt[i].mv, vt[i].sr, vt[i].ps, vt[i].bz};
            a = {18'd0, vt[i].mv ? m_axis_tdata : 8'h00,
                 vt[i].mv ? m_axis_tlast : 1'b0,
                 vt[i].mv ? m_axis_tuser : 1'b0,
                 m_axis_tvalid, s_axis_tready, paused, busy};
            chk($sformatf("vec%0d", i), a, e);
            tick;
        end

        // Full PAUSE frame, no backpressure.
        do_reset;
        tx_pause_req    = 1'b1;
        tx_pause_quanta = 16'h1234;
        tick;
        tx_pause_req = 1'b0;
        collect(16'h1234, 1'b0, 0, 60);
        @(negedge clk);
        chk("after_pause_idle", {30'd0, m_axis_tvalid, busy}, 32'd0);
        tick;

        // GMII hold-off of 2 quanta.
        do_reset;
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd2;
        tick;
        rx_pause_valid = 1'b0;
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = 8'hA5;
        s_axis_tlast   = 1'b1;
        cnt = 0;
        rel = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (m_axis_tvalid) begin
                rel = 1'b1;
                break;
            end
            if (paused) cnt++;
            tick;
        end
        chk("gmii_pause_cycles", cnt, 128);
        chk("gmii_release", {22'd0, rel, m_axis_tdata, paused}, {22'd0, 1'b1, 8'hA5, 1'b0});
        tick;
        s_axis_tvalid = 1'b0;

        // MII hold-off with clk_enable every other cycle.
        do_reset;
        mii_select      = 1'b1;
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd2;
        tick;
        rx_pause_valid = 1'b0;
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = 8'h5A;
        s_axis_tlast   = 1'b1;
        cnt = 0;
        rel = 1'b0;
        for (int c = 1; c < 2000; c++) begin
            clk_enable = 1'(c % 2 == 0);
            @(negedge clk);
            if (m_axis_tvalid) begin
                rel = 1'b1;
                break;
            end
            if (paused) cnt++;
            tick;
        end
        chk("mii_pause_cycles", cnt, 512);
        chk("mii_release", {23'd0, rel, m_axis_tdata}, {23'd0, 1'b1, 8'h5A});
        tick;
        s_axis_tvalid = 1'b0;
        clk_enable    = 1'b1;
        mii_select    = 1'b0;

        // RX pause mid user frame, then quanta 0 release.
        do_reset;
        for (int i = 0; i < 10; i++) begin
            s_axis_tvalid   = 1'b1;
            s_axis_tdata    = 8'h40 + 8'(i);
            s_axis_tlast    = 1'(i == 9);
            rx_pause_valid  = 1'(i == 4);
            rx_pause_quanta = 16'd3;
            @(negedge clk);
            chk($sformatf("midframe_byte%0d", i),
                {22'd0, m_axis_tvalid, m_axis_tdata, m_axis_tlast},
                {22'd0, 1'b1, 8'h40 + 8'(i), 1'(i == 9)});
            tick;
        end
        rx_pause_valid = 1'b0;
        s_axis_tdata   = 8'h50;
        s_axis_tlast   = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (m_axis_tvalid || s_axis_tready || !paused) bad++;
            tick;
        end
        chk("next_frame_held", bad, 0);
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd0;
        @(negedge clk);
        chk("zero_quanta_same_cycle", {31'd0, m_axis_tvalid}, 32'd0);
        tick;
        rx_pause_valid = 1'b0;
        @(negedge clk);
        chk("zero_quanta_release", {22'd0, m_axis_tvalid, m_axis_tdata, paused},
            {22'd0, 1'b1, 8'h50, 1'b0});
        tick;
        s_axis_tvalid = 1'b0;

        // Two requests during a user frame, last wins, random backpressure.
        do_reset;
        for (int i = 0; i < 6; i++) begin
            s_axis_tvalid   = 1'b1;
            s_axis_tdata    = 8'h60 + 8'(i);
            s_axis_tlast    = 1'(i == 5);
            tx_pause_req    = 1'(i == 2 || i == 4);
            tx_pause_quanta = (i == 4) ? 16'hFFFF : 16'h0001;
            @(negedge clk);
            chk($sformatf("user_byte%0d", i),
                {22'd0, m_axis_tvalid, m_axis_tdata, s_axis_tready},
                {22'd0, 1'b1, 8'h60 + 8'(i), 1'b1});
            tick;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        tx_pause_req  = 1'b0;
        collect(16'hFFFF, 1'b1, 0, 60);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_axis_tvalid || busy) bad++;
            tick;
        end
        chk("no_second_pause", bad, 0);

        // Reset in the middle of a PAUSE frame with another request pending.
        do_reset;
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd100;
        tx_pause_req    = 1'b1;
        tx_pause_quanta = 16'h00AA;
        tick;
        rx_pause_valid = 1'b0;
        tx_pause_req   = 1'b0;
        collect(16'h00AA, 1'b0, 0, 20);
        tx_pause_req    = 1'b1;
        tx_pause_quanta = 16'h0055;
        collect(16'h00AA, 1'b0, 20, 21);
        tx_pause_req = 1'b0;
        collect(16'h00AA, 1'b0, 21, 30);
        rst = 1'b1;
        @(negedge clk);
        chk("paused_before_reset", {31'd0, paused}, 32'd1);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_midframe", {29'd0, m_axis_tvalid, paused, busy}, 32'd0);
        tick;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_axis_tvalid || busy) bad++;
            tick;
        end
        chk("no_frame_after_reset", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
